// File: rtl/trace_pkg.sv
// Shared record layout and kind codes for the retire-event trace buffer.
package trace_pkg;

   localparam logic KIND_GRF = 1'b0;
   localparam logic KIND_DM  = 1'b1;

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Circular record store with two in-order write ports and one read port.
// wr1 lands in the slot after wr0 and is only legal when wr0 is also enabled.
module trace_fifo_2w1r
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr0_en,
   input  trace_rec_t       wr0_rec,
   input  logic             wr1_en,
   input  trace_rec_t       wr1_rec,
   input  logic             rd_en,
   output trace_rec_t       rd_rec,
   output logic [PTR_W:0]   count
);

   localparam int CNT_W = PTR_W + 1;

   trace_rec_t             mem [DEPTH];
   logic       [PTR_W-1:0] wr_ptr;
   logic       [PTR_W-1:0] rd_ptr;
   logic       [PTR_W-1:0] wr1_ptr;

   assign wr1_ptr = wr_ptr + PTR_W'(1);
   assign rd_rec  = mem[rd_ptr];

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr0_en) mem[wr_ptr]  <= wr0_rec;
      if (wr1_en) mem[wr1_ptr] <= wr1_rec;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
         rd_ptr <= rd_ptr + PTR_W'(rd_en);
         count  <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/wb_trace_fifo.sv
// Buffers GRF (W stage) and DM (M stage) writes in program order and streams
// them out as records; stalls the core when a two-event cycle might not fit.
module wb_trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        grf_we,
   input  logic [31:0] grf_pc,
   input  logic [4:0]  grf_addr,
   input  logic [31:0] grf_data,
   input  logic        dm_we,
   input  logic [31:0] dm_pc,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [31:0] out_pc,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic        trace_stall,
   output logic        overflow,
   output logic [31:0] evt_count
);

   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic             grf_ev;
   logic             dm_ev;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] free;
   logic [CNT_W-1:0] room;
   logic             wr0_en;
   logic             wr1_en;
   logic             drop;
   trace_rec_t       grf_rec;
   trace_rec_t       dm_rec;
   trace_rec_t       wr0_rec;
   trace_rec_t       head;

   // Writes to $0 never change architectural state, so they are not traced.
   assign grf_ev  = grf_we && (grf_addr != 5'd0);
   assign dm_ev   = dm_we;
   assign grf_rec = '{kind: KIND_GRF, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_data};
   assign dm_rec  = '{kind: KIND_DM,  pc: dm_pc,  addr: dm_addr,          data: dm_data};

   assign pop  = out_valid && out_ready;
   assign free = DEPTH_C - count;
   assign room = free + CNT_W'(pop);

   // The older GRF event claims the first slot; DM follows in the next one.
   always_comb begin
      wr0_rec = grf_ev ? grf_rec : dm_rec;
      wr0_en  = (grf_ev || dm_ev) && (room != '0);
      wr1_en  = grf_ev && dm_ev && (room >= CNT_W'(2));
      drop    = ((grf_ev || dm_ev) && !wr0_en) || (grf_ev && dm_ev && !wr1_en);
   end

   trace_fifo_2w1r #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr0_en  (wr0_en),
      .wr0_rec (wr0_rec),
      .wr1_en  (wr1_en),
      .wr1_rec (dm_rec),
      .rd_en   (pop),
      .rd_rec  (head),
      .count   (count)
   );

   assign out_valid   = (count != '0);
   assign out_kind    = out_valid ? head.kind : 1'b0;
   assign out_pc      = out_valid ? head.pc   : 32'd0;
   assign out_addr    = out_valid ? head.addr : 32'd0;
   assign out_data    = out_valid ? head.data : 32'd0;
   assign trace_stall = (free < CNT_W'(2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         evt_count <= 32'd0;
      end else begin
         if (drop) overflow <= 1'b1;
         evt_count <= evt_count + 32'(wr0_en) + 32'(wr1_en);
      end
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: reset, ordering, filtering, full/overflow, mid-stream reset.
module tb_wb_trace_fifo;
   import trace_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        grf_we;
   logic [31:0] grf_pc;
   logic [4:0]  grf_addr;
   logic [31:0] grf_data;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_addr;
   logic [31:0] dm_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic        trace_stall;
   logic        overflow;
   logic [31:0] evt_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .grf_we      (grf_we),
      .grf_pc      (grf_pc),
      .grf_addr    (grf_addr),
      .grf_data    (grf_data),
      .dm_we       (dm_we),
      .dm_pc       (dm_pc),
      .dm_addr     (dm_addr),
      .dm_data     (dm_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_kind    (out_kind),
      .out_pc      (out_pc),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .trace_stall (trace_stall),
      .overflow    (overflow),
      .evt_count   (evt_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_data = '0;
      dm_we  = 1'b0; dm_pc  = '0; dm_addr  = '0; dm_data  = '0;
   endtask

   task automatic head(input string tag, input logic kind, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] data);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".kind"},  32'(out_kind),  32'(kind));
      chk({tag, ".pc"},    out_pc,   pc);
      chk({tag, ".addr"},  out_addr, addr);
      chk({tag, ".data"},  out_data, data);
   endtask

   initial begin
      reset = 1'b0;
      out_ready = 1'b0;
      idle();

      // 1: reset held three cycles
      repeat (3) step();
      chk("rst.valid",    32'(out_valid),   32'd0);
      chk("rst.stall",    32'(trace_stall), 32'd0);
      chk("rst.overflow", 32'(overflow),    32'd0);
      chk("rst.evt",      evt_count,        32'd0);
      chk("rst.data",     out_data,         32'd0);
      reset = 1'b1;
      step();
      chk("rel.valid", 32'(out_valid), 32'd0);
      chk("rel.evt",   evt_count,      32'd0);

      // 2: single GRF event
      out_ready = 1'b1;
      grf_we = 1'b1; grf_pc = 32'h3000; grf_addr = 5'd5; grf_data = 32'h1234;
      step();
      idle();
      head("t2", KIND_GRF, 32'h3000, 32'd5, 32'h1234);
      step();
      chk("t2.empty", 32'(out_valid), 32'd0);
      chk("t2.evt",   evt_count,      32'd1);

      // 3: GRF and DM in one cycle, GRF first
      grf_we = 1'b1; grf_pc = 32'h3004; grf_addr = 5'd8; grf_data = 32'hAA;
      dm_we  = 1'b1; dm_pc  = 32'h3008; dm_addr  = 32'h10; dm_data = 32'hBB;
      step();
      idle();
      chk("t3.evt", evt_count, 32'd3);
      head("t3.first", KIND_GRF, 32'h3004, 32'd8, 32'hAA);
      step();
      head("t3.second", KIND_DM, 32'h3008, 32'h10, 32'hBB);
      step();
      chk("t3.empty", 32'(out_valid), 32'd0);

      // 4: $0 write is filtered
      grf_we = 1'b1; grf_pc = 32'h300C; grf_addr = 5'd0; grf_data = 32'hFFFF_FFFF;
      step();
      idle();
      chk("t4.valid", 32'(out_valid), 32'd0);
      chk("t4.evt",   evt_count,      32'd3);

      // 5: fill with DM events while blocked
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         dm_we = 1'b1; dm_pc = 32'h4000 + 32'(4 * i); dm_addr = 32'(4 * i); dm_data = 32'h100 + 32'(i);
         step();
         if (i == 13) chk("t5.stall14", 32'(trace_stall), 32'd0);
      end
      chk("t5.stall15", 32'(trace_stall), 32'd1);
      chk("t5.ovf0",    32'(overflow),    32'd0);
      grf_we = 1'b1; grf_pc = 32'h5000; grf_addr = 5'd9; grf_data = 32'h900;
      dm_we  = 1'b1; dm_pc  = 32'h5004; dm_addr  = 32'h80; dm_data = 32'h999;
      step();
      idle();
      chk("t5.ovf1",    32'(overflow),    32'd1);
      chk("t5.evt",     evt_count,        32'd19);
      chk("t5.stallF",  32'(trace_stall), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         head($sformatf("t5.drain%0d", i), KIND_DM, 32'h4000 + 32'(4 * i), 32'(4 * i), 32'h100 + 32'(i));
         step();
      end
      head("t5.drain15", KIND_GRF, 32'h5000, 32'd9, 32'h900);
      step();
      chk("t5.empty",  32'(out_valid),   32'd0);
      chk("t5.stall0", 32'(trace_stall), 32'd0);
      chk("t5.ovfHeld", 32'(overflow),   32'd1);

      // 6: reset in the middle of a drain
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dm_we = 1'b1; dm_pc = 32'h6000 + 32'(4 * i); dm_addr = 32'h200 + 32'(4 * i); dm_data = 32'h500 + 32'(i);
         step();
      end
      idle();
      out_ready = 1'b1;
      head("t6.pre0", KIND_DM, 32'h6000, 32'h200, 32'h500);
      step();
      step();
      head("t6.pre2", KIND_DM, 32'h6008, 32'h208, 32'h502);
      #2;
      reset = 1'b0;
      #1;
      chk("t6.asyncValid", 32'(out_valid), 32'd0);
      chk("t6.asyncOvf",   32'(overflow),  32'd0);
      chk("t6.asyncEvt",   evt_count,      32'd0);
      step();
      reset = 1'b1;
      grf_we = 1'b1; grf_pc = 32'h7000; grf_addr = 5'd3; grf_data = 32'h77;
      step();
      idle();
      head("t6.post", KIND_GRF, 32'h7000, 32'd3, 32'h77);
      step();
      chk("t6.alone", 32'(out_valid), 32'd0);
      chk("t6.evt",   evt_count,      32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
